regfile_dump_reader: RTL and testbench

Debug read-out engine that sits on a spare read port of the pipeline register file and streams a contiguous address range out over a valid/ready handshake. It drives the register file read address and samples the combinational read data. Each captured word is presented together with its register index to a host-side consumer, such as a UART bridge or a testbench monitor. The pipeline writes the register file on the falling edge. This block samples on the rising edge, so every captured word reflects all writes completed before that rising edge.

---
 rtl/regfile_dump_reader.sv | 117 +++++++++++
 tb/tb_regfile_dump_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Debug read-out engine on a spare register-file read port. Walks
//            a contiguous (wrapping) address range and streams each register
//            value with its index over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
  parameter int ADDR = 5,
  parameter int NUMB = 1 << ADDR,
  parameter int SIZE = 32
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Start,
  input  logic            Abort,
  input  logic [ADDR-1:0] First_Addr,
  input  logic [ADDR-1:0] Last_Addr,
  output logic [ADDR-1:0] R_Addr,
  input  logic [SIZE-1:0] R_Data,
  output logic [SIZE-1:0] Dout,
  output logic [ADDR-1:0] Dout_Addr,
  output logic            Dout_Valid,
  input  logic            Dout_Ready,
  output logic            Busy,
  output logic            Done
);

  localparam logic [ADDR-1:0] c_PTR_MAX = ADDR'(NUMB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [ADDR-1:0] r_ptr;
  logic [ADDR-1:0] r_last;
  logic            w_handshake;
  logic [ADDR-1:0] w_ptr_next;

  // The read port address follows the pointer with no register stage so the
  // combinational read data is ready to capture in the READ cycle.
  assign R_Addr      = r_ptr;
  assign w_handshake = Dout_Valid & Dout_Ready;
  // Pointer advance wraps from the top register back to index 0.
  assign w_ptr_next  = (r_ptr == c_PTR_MAX) ? '0 : r_ptr + 1'b1;

  // Dump sequencer: READ captures a word, HOLD waits for the consumer.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_last     <= '0;
      Dout       <= '0;
      Dout_Addr  <= '0;
      Dout_Valid <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_ptr   <= First_Addr;
            r_last  <= Last_Addr;
            Busy    <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (Abort) begin
            Dout_Valid <= 1'b0;
            Busy       <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            Dout       <= R_Data;
            Dout_Addr  <= r_ptr;
            Dout_Valid <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Abort wins over a handshake on the same edge: the word is dropped.
          if (Abort) begin
            Dout_Valid <= 1'b0;
            Busy       <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_handshake) begin
            Dout_Valid <= 1'b0;
            if (r_ptr == r_last) begin
              Busy    <= 1'b0;
              Done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ptr   <= w_ptr_next;
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Directed self-checking bench for regfile_dump_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [4:0]  First_Addr = '0;
  logic [4:0]  Last_Addr = '0;
  logic [4:0]  R_Addr;
  logic [31:0] R_Data;
  logic [31:0] Dout;
  logic [4:0]  Dout_Addr;
  logic        Dout_Valid;
  logic        Dout_Ready = 1'b0;
  logic        Busy;
  logic        Done;

  logic [31:0] regs [32];
  assign R_Data = regs[R_Addr];

  int total = 0;
  int bad   = 0;

  logic [4:0]  q_addr [$];
  logic [31:0] q_data [$];

  regfile_dump_reader #(.ADDR(5), .NUMB(32), .SIZE(32)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .Start      (Start),
    .Abort      (Abort),
    .First_Addr (First_Addr),
    .Last_Addr  (Last_Addr),
    .R_Addr     (R_Addr),
    .R_Data     (R_Data),
    .Dout       (Dout),
    .Dout_Addr  (Dout_Addr),
    .Dout_Valid (Dout_Valid),
    .Dout_Ready (Dout_Ready),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one dump; hold = cycles Dout_Ready stays low on each presented word.
  // Every valid sample is checked against the next expected index and the
  // register model; accepted words are logged in q_addr/q_data.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int hold,
                          output int ncyc, output int nbusy);
    int   waitc;
    logic acc;
    logic [4:0] exp_a;
    q_addr.delete();
    q_data.delete();
    First_Addr = f;
    Last_Addr  = l;
    Start      = 1'b1;
    tick();
    Start = 1'b0;
    nbusy = int'(Busy);
    ncyc  = 0;
    waitc = 0;
    Dout_Ready = (hold == 0);
    while (ncyc < 400) begin
      if (Dout_Valid) begin
        exp_a = f + 5'(q_addr.size());
        chk("word_addr", 32'(Dout_Addr), 32'(exp_a));
        chk("word_data", Dout, regs[exp_a]);
        if (waitc >= hold) Dout_Ready = 1'b1;
        else begin
          Dout_Ready = 1'b0;
          waitc++;
        end
      end else if (hold != 0) begin
        Dout_Ready = 1'b0;
      end
      acc = Dout_Valid & Dout_Ready;
      if (acc) begin
        q_addr.push_back(Dout_Addr);
        q_data.push_back(Dout);
        waitc = 0;
      end
      tick();
      ncyc++;
      nbusy += int'(Busy);
      if (Done) break;
    end
    chk("done_seen", 32'(Done), 32'd1);
    Dout_Ready = 1'b0;
    tick();
    chk("done_single_pulse", 32'(Done), 32'd0);
  endtask

  initial begin
    int nc, nb, cnt, c;
    logic v, aborted;

    for (int i = 0; i < 32; i++) regs[i] = 32'(i);

    // Reset
    #3 Clr = 1'b1;
    tick();
    tick();
    chk("rst_raddr", 32'(R_Addr), 0);
    chk("rst_dout", Dout, 0);
    chk("rst_dout_addr", 32'(Dout_Addr), 0);
    chk("rst_valid", 32'(Dout_Valid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    @(negedge Clk);
    Clr = 1'b0;
    tick();

    // Full dump 0..31, ready tied high
    run_dump(5'd0, 5'd31, 0, nc, nb);
    chk("full_words", 32'(q_addr.size()), 32);
    chk("full_done_cycle", 32'(nc), 64);
    chk("full_busy_cycles", 32'(nb), 64);
    chk("full_last_addr", 32'(q_addr[31]), 31);

    // Backpressure 5..7 with 3 cycles of Dout_Ready low per word
    run_dump(5'd5, 5'd7, 3, nc, nb);
    chk("bp_words", 32'(q_addr.size()), 3);
    chk("bp_w0", {q_addr[0], q_data[0][26:0]}, {5'd5, 27'd5});
    chk("bp_w2", {q_addr[2], q_data[2][26:0]}, {5'd7, 27'd7});
    chk("bp_done_cycle", 32'(nc), 15);
    chk("bp_busy_cycles", 32'(nb), 15);

    // Wrap-around 30 -> 1
    run_dump(5'd30, 5'd1, 0, nc, nb);
    chk("wrap_words", 32'(q_addr.size()), 4);
    chk("wrap_a0", 32'(q_addr[0]), 30);
    chk("wrap_a1", 32'(q_addr[1]), 31);
    chk("wrap_a2", 32'(q_addr[2]), 0);
    chk("wrap_a3", 32'(q_addr[3]), 1);
    chk("wrap_done_cycle", 32'(nc), 8);

    // Abort at word 10, with an ignored Start at word 3
    First_Addr = 5'd0;
    Last_Addr  = 5'd31;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
    Dout_Ready = 1'b1;
    cnt = 0;
    c = 0;
    aborted = 1'b0;
    while (c < 200 && !aborted) begin
      v = Dout_Valid;
      if (v) begin
        chk("abort_seq_addr", 32'(Dout_Addr), 32'(cnt));
        if (cnt == 3) begin
          First_Addr = 5'd20;
          Last_Addr  = 5'd21;
          Start      = 1'b1;
        end
        if (cnt == 10) Abort = 1'b1;
      end
      tick();
      c++;
      Start = 1'b0;
      chk("abort_no_done", 32'(Done), 0);
      if (Abort) begin
        Abort   = 1'b0;
        aborted = 1'b1;
      end else if (v) begin
        cnt++;
      end
    end
    chk("abort_reached", 32'(aborted), 1);
    chk("abort_accepted", 32'(cnt), 10);
    chk("abort_valid", 32'(Dout_Valid), 0);
    chk("abort_busy", 32'(Busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle_done", 32'(Done), 0);
      chk("abort_idle_valid", 32'(Dout_Valid), 0);
    end
    Dout_Ready = 1'b0;

    // Reset mid-dump while HOLD presents word 5
    run_dump(5'd4, 5'd4, 0, nc, nb);
    First_Addr = 5'd0;
    Last_Addr  = 5'd31;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
    Dout_Ready = 1'b1;
    c = 0;
    while (c < 100 && !(Dout_Valid && Dout_Addr == 5'd5)) begin
      tick();
      c++;
    end
    Dout_Ready = 1'b0;
    chk("mid_in_hold", 32'(Dout), 5);
    Clr = 1'b1;
    #2;
    chk("mid_rst_raddr", 32'(R_Addr), 0);
    chk("mid_rst_dout", Dout, 0);
    chk("mid_rst_dout_addr", 32'(Dout_Addr), 0);
    chk("mid_rst_valid", 32'(Dout_Valid), 0);
    chk("mid_rst_busy", 32'(Busy), 0);
    chk("mid_rst_done", 32'(Done), 0);
    @(negedge Clk);
    Clr = 1'b0;
    tick();
    run_dump(5'd4, 5'd4, 0, nc, nb);
    chk("single_words", 32'(q_addr.size()), 1);
    chk("single_addr", 32'(q_addr[0]), 4);
    chk("single_done_cycle", 32'(nc), 2);

    // Register write lands while the dump is reading index 10
    fork
      run_dump(5'd10, 5'd13, 0, nc, nb);
      begin
        @(posedge Clk);
        @(negedge Clk);
        regs[12] = 32'hDEADBEEF;
      end
    join
    chk("cw_words", 32'(q_addr.size()), 4);
    chk("cw_addr", 32'(q_addr[2]), 12);
    chk("cw_data", q_data[2], 32'hDEADBEEF);
    chk("cw_next", q_data[3], 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
